imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the imem_loader.
// The loader takes the master side; the byte source / memory takes the slave side.
interface imem_loader_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         we;
  logic [7:0]   waddr;
  logic [N-1:0] wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into LEN words of N bits and writes them to imem.
// Optional running XOR checksum of written words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int N   = 32,   // multiple of 8, >= 8
  parameter int LEN = 256   // 1..256 words per load
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                busy,
  output logic                done
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [N-1:0]        checksum
`endif
);

  localparam int         BPW       = N / 8;
  localparam int         CW        = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [7:0] LAST_ADDR = 8'(LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_bcnt;
  logic [7:0]    r_addr;
  logic [N-1:0]  r_word;
  logic          r_we;
  logic [7:0]    r_waddr;
  logic [N-1:0]  r_wdata;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_last_byte;
  logic          w_start_ok;
  logic [N-1:0]  w_word_next;

  assign w_accept    = bus.in_valid && (r_state == LOAD);
  assign w_last_byte = (r_bcnt == CW'(BPW - 1));
  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_word_next = r_word;
    w_word_next[8*int'(r_bcnt) +: 8] = bus.in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= LOAD;
            r_bcnt  <= '0;
            r_addr  <= '0;
            r_word  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_word <= w_word_next;
            if (w_last_byte) begin
              r_bcnt  <= '0;
              r_state <= WRITE;
              r_we    <= 1'b1;
              r_waddr <= r_addr;
              r_wdata <= w_word_next;
            end else begin
              r_bcnt <= r_bcnt + CW'(1);
            end
          end
        end
        WRITE: begin
          // Address saturates at LAST_ADDR: the final word ends the load instead of wrapping.
          if (r_addr == LAST_ADDR) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_addr  <= r_addr + 8'd1;
            r_state <= LOAD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [N-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (r_state == WRITE) begin
      r_checksum <= r_checksum ^ r_wdata;
    end
  end

  assign checksum = r_checksum;
`endif

  assign bus.in_ready = (r_state == LOAD);
  assign bus.we       = r_we;
  assign bus.waddr    = r_waddr;
  assign bus.wdata    = r_wdata;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: three loaders (LEN=1, 3, 256) share one byte stream; only the selected one is started.
// A negedge monitor pops the expected-write scoreboard on every we pulse.
module tb_imem_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic        tb_valid;
  logic [7:0]  tb_data;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] cks_a, cks_b, cks_c;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   start_cyc;
  int   sel   = 0;
  int   dcyc;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader_if #(.N(32)) if_a ();
  imem_loader_if #(.N(32)) if_b ();
  imem_loader_if #(.N(32)) if_c ();

  assign if_a.in_valid = tb_valid;
  assign if_a.in_data  = tb_data;
  assign if_b.in_valid = tb_valid;
  assign if_b.in_data  = tb_data;
  assign if_c.in_valid = tb_valid;
  assign if_c.in_data  = tb_data;

  imem_loader #(.N(32), .LEN(1)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .bus(if_a.master),
    .busy(busy_a), .done(done_a)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(cks_a)
`endif
  );

  imem_loader #(.N(32), .LEN(3)) u_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .bus(if_b.master),
    .busy(busy_b), .done(done_b)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(cks_b)
`endif
  );

  imem_loader #(.N(32), .LEN(256)) u_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .bus(if_c.master),
    .busy(busy_c), .done(done_c)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(cks_c)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int s);
    case (s)
      0:       return if_a.in_ready;
      1:       return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  function automatic logic done_of(input int s);
    case (s)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5a, b + 8'h3c};
  endfunction

  task automatic mon(input int s, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    if (s != sel) begin
      check("stray_we_dut", 64'(s), 64'(sel));
    end else begin
      check("we_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("waddr", 64'(a), 64'(e.addr));
        check("wdata", 64'(d), 64'(e.data));
      end
    end
  endtask

  always @(negedge clk) begin
    if (if_a.we) mon(0, if_a.waddr, if_a.wdata);
    if (if_b.we) mon(1, if_b.waddr, if_b.wdata);
    if (if_c.we) mon(2, if_c.waddr, if_c.wdata);
  end

  task automatic do_start(input int s);
    sel        = s;
    start_v[s] = 1'b1;
    @(posedge clk); #1;
    start_v[s] = 1'b0;
    start_cyc  = cyc;
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input bit gap);
    bit got = 1'b0;
    if (gap) begin
      tb_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    tb_valid = 1'b1;
    tb_data  = b;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = rdy_of(s);
    end
    if (!got) check("ready_timeout", 64'(rdy_of(s)), 64'd1);
    else begin
      @(posedge clk); #1;
    end
    tb_valid = 1'b0;
  endtask

  task automatic send_word(input int s, input logic [7:0] a, input logic [31:0] w, input bit gap);
    sb.push_back('{addr: a, data: w});
    for (int k = 0; k < 4; k++) send_byte(s, w[8*k +: 8], gap);
  endtask

  task automatic wait_done(input int s, input int budget, output int dc);
    bit got = 1'b0;
    dc = -1;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (done_of(s)) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    if (!got) check("done_timeout", 64'(done_of(s)), 64'd1);
  endtask

  initial begin
    logic [31:0] w1;
    reset    = 1'b0;
    start_v  = 3'b000;
    tb_valid = 1'b0;
    tb_data  = 8'h00;

    // Reset state, with start held on DUT A to show it is ignored under reset.
    repeat (2) @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    @(negedge clk);
    check("rst_busy_a",  64'(busy_a), 64'd0);
    check("rst_ready_a", 64'(if_a.in_ready), 64'd0);
    check("rst_done_b",  64'(done_b), 64'd0);
    check("rst_we_c",    64'(if_c.we), 64'd0);
    check("rst_waddr_c", 64'(if_c.waddr), 64'd0);
    check("rst_wdata_b", 64'(if_b.wdata), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("rst_cks_c", 64'(cks_c), 64'd0);
`endif
    @(posedge clk); #1 reset = 1'b1;

    // LEN=1, back-to-back bytes.
    do_start(0);
    check("a_busy_load",  64'(busy_a), 64'd1);
    check("a_ready_load", 64'(if_a.in_ready), 64'd1);
    send_word(0, 8'h00, 32'hd29fffe1, 1'b0);
    wait_done(0, 20, dcyc);
    check("a_done_latency", 64'(dcyc - start_cyc), 64'd5);
    check("a_done_busy",  64'(busy_a), 64'd0);
    check("a_done_ready", 64'(if_a.in_ready), 64'd0);
    check("a_done_we",    64'(if_a.we), 64'd0);
    check("a_hold_wdata", 64'(if_a.wdata), 64'hd29fffe1);
    check("a_sb_drained", 64'(sb.size()), 64'd0);

    // Reset after two bytes of word 0 discards the partial word.
    do_start(1);
    send_byte(1, 8'haa, 1'b0);
    send_byte(1, 8'hbb, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    check("b_rst_busy",  64'(busy_b), 64'd0);
    check("b_rst_ready", 64'(if_b.in_ready), 64'd0);
    check("a_rst_done",  64'(done_a), 64'd0);
    check("a_rst_wdata", 64'(if_a.wdata), 64'd0);
    tb_valid = 1'b1;
    tb_data  = 8'hcc;
    repeat (4) @(posedge clk);
    #1 tb_valid = 1'b0;

    // LEN=3 with in_valid randomly low.
    do_start(1);
    send_word(1, 8'd0, 32'hd29fffe1, 1'b1);
    send_word(1, 8'd1, 32'hf8000001, 1'b1);
    send_word(1, 8'd2, 32'hb400001f, 1'b1);
    wait_done(1, 50, dcyc);
    check("b_sb_drained", 64'(sb.size()), 64'd0);
    check("b_done_busy",  64'(busy_b), 64'd0);
    check("b_hold_waddr", 64'(if_b.waddr), 64'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("b_checksum", 64'(cks_b), 64'h9e9fffff);
    @(negedge clk);
    check("b_checksum_stable", 64'(cks_b), 64'h9e9fffff);
`endif

    // Restart from DONE, with a start pulse mid-LOAD that must be ignored.
    do_start(1);
    check("b_restart_done", 64'(done_b), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("b_restart_cks", 64'(cks_b), 64'd0);
`endif
    send_word(1, 8'd0, 32'h01234567, 1'b0);
    w1 = 32'h89abcdef;
    sb.push_back('{addr: 8'd1, data: w1});
    send_byte(1, w1[7:0], 1'b0);
    send_byte(1, w1[15:8], 1'b0);
    start_v[1] = 1'b1;
    @(posedge clk); #1 start_v[1] = 1'b0;
    check("b_midload_busy",  64'(busy_b), 64'd1);
    check("b_midload_ready", 64'(if_b.in_ready), 64'd1);
    send_byte(1, w1[23:16], 1'b1);
    send_byte(1, w1[31:24], 1'b0);
    send_word(1, 8'd2, 32'h5a5aa5a5, 1'b1);
    wait_done(1, 50, dcyc);
    check("b2_sb_drained", 64'(sb.size()), 64'd0);

    // LEN=256, in_valid held high.
    do_start(2);
    for (int i = 0; i < 256; i++) send_word(2, 8'(i), pat(i), 1'b0);
    wait_done(2, 20, dcyc);
    check("c_done_latency", 64'(dcyc - start_cyc), 64'd1280);
    check("c_last_waddr",   64'(if_c.waddr), 64'hff);
    check("c_sb_drained",   64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("c_done_sticky",  64'(done_c), 64'd1);
    check("c_done_we",      64'(if_c.we), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
